pattern_sched_ctrl: RTL and testbench
=====================================

Name: pattern_sched_ctrl

Overview:
Sequencing controller for the colour-bar test-pattern datapath in the i_sysclk domain. Gates the pixel timing generator on panel-configuration completion and holds the output black for a programmable number of start-up frames. It then steps the pattern selector on frame boundaries, either automatically on a dwell timer or on a host request via a valid/ready handshake. Sits between the panel configuration engine and the pattern generator/timing generator pair.

Parameters:
NUM_PATTERNS, 8, number of selectable patterns; legal indices 0..NUM_PATTERNS-1
PAT_W, 3, pattern index width; must hold NUM_PATTERNS-1
FRAME_W, 9, frame counter width
BLANK_FRAMES, 121, frames forced black after generator enable before RUN
DWELL_FRAMES, 60, frames per pattern in auto-advance mode; must be >=1
RSTN_FRAME, 6, frame count at which o_pixel_rstn releases

Ports:
i_sysclk  in  1  pixel/system clock
w_sysclk_arstn  in  1  asynchronous, active-low reset
i_confdone  in  1  panel config done, from the fb_clk domain (asynchronous level)
i_vs  in  1  vsync from the timing generator, active-high
i_req_valid  in  1  host pattern request valid
i_req_pattern  in  PAT_W  requested pattern index
i_req_hold  in  1  1 = freeze on the requested pattern; 0 = resume auto-advance from it
o_req_ready  out  1  request can be accepted
o_req_err  out  1  one-cycle pulse: accepted request was out of range
o_gen_rstn  out  1  timing generator enable (active-low reset)
o_pixel_rstn  out  1  downstream pixel pipeline reset release
o_blank  out  1  force pattern output to zero
o_pattern_sel  out  PAT_W  active pattern index
o_frame_cnt  out  FRAME_W  frame counter
o_state  out  2  FSM state, for debug

Behaviour:
- Reset values: o_gen_rstn=0, o_pixel_rstn=0, o_blank=1, o_pattern_sel=0, o_frame_cnt=0, o_req_ready=0, o_req_err=0, o_state=IDLE (0). All outputs are registered.
- i_confdone passes through a 2-flop synchroniser, giving conf_s.
- Frame tick: i_vs is registered to vs_d. tick = vs_d & ~i_vs (falling edge, one-cycle pulse). Ticks are ignored in IDLE and WAIT_CONF.
- FSM encoding: IDLE=0, WAIT_CONF=1, BLANK=2, RUN=3.
  - IDLE: go to WAIT_CONF on the next cycle.
  - WAIT_CONF: o_gen_rstn=0; frame_cnt, blank_cnt and dwell_cnt are cleared. When conf_s=1, go to BLANK; o_gen_rstn=1 is registered in the same transition.
  - BLANK: o_blank=1. blank_cnt increments on each tick. On the tick where blank_cnt==BLANK_FRAMES-1, go to RUN with o_pattern_sel=0 and dwell_cnt=0. o_blank drops on the cycle after that tick.
  - RUN: o_blank=0. On each tick, apply the first matching rule:
    1. A pending request exists: apply it.
    2. Hold mode is set: no change.
    3. dwell_cnt==DWELL_FRAMES-1: advance pattern (NUM_PATTERNS-1 wraps to 0) and clear dwell_cnt.
    4. Otherwise: dwell_cnt+1.
  - conf_s=0 in BLANK or RUN: return to WAIT_CONF on the next cycle. This forces o_gen_rstn=0, o_pixel_rstn=0, o_blank=1, o_pattern_sel=0, clears hold mode and drops any pending request.
- Frame counter: increments on every tick in BLANK/RUN and wraps 2^FRAME_W-1 to 0. When o_frame_cnt==RSTN_FRAME in BLANK/RUN, o_pixel_rstn=1 (sticky until WAIT_CONF or reset). A counter wrap does not re-trigger or clear it.
- Request handshake:
  - o_req_ready = (state==RUN) & ~pending.
  - Accept = i_req_valid & o_req_ready. Pattern and hold bit are latched as pending.
  - A pending request is applied on the next tick, or on the same cycle if accept coincides with a tick. Applying sets o_pattern_sel=req, dwell_cnt=0, hold mode=i_req_hold, and clears pending.
  - Out-of-range index (>=NUM_PATTERNS): the request is accepted, o_req_err pulses one cycle after accept, and the request is discarded with no pending state and no pattern change.
  - i_req_valid outside RUN is not accepted; the requester holds it.
- Latency: pattern changes take effect on the cycle after the tick, so the new pattern is stable for the entire following frame.

Test Plan:
- Reset, then conf_s rises at t0 -> o_gen_rstn=1 at t0+1; o_blank=1; o_pixel_rstn rises on the tick making o_frame_cnt=6; RUN entered after 121 ticks with o_pattern_sel=0 and o_blank=0.
- Auto-advance with DWELL_FRAMES=2, NUM_PATTERNS=8 -> o_pattern_sel steps 0,0,1,1,...,7,7,0 on successive ticks (wrap checked).
- Request pattern 5 with hold=1 mid-frame -> o_req_ready drops until the next tick; after the tick o_pattern_sel=5 and stays 5 for 10+ ticks. Then request 2 with hold=0 -> 2 for DWELL_FRAMES ticks, then 3.
- Request asserted on the exact tick cycle with dwell_cnt==DWELL_FRAMES-1 -> the request wins: o_pattern_sel=req, not the auto-advanced value.
- Request pattern 9 with NUM_PATTERNS=8 -> accepted, o_req_err pulses once, o_pattern_sel unchanged.
- Drop i_confdone during RUN -> within 3 cycles: WAIT_CONF, o_gen_rstn=0, o_pixel_rstn=0, o_blank=1, o_pattern_sel=0, o_frame_cnt=0. Reassert i_confdone -> the full BLANK sequence repeats. Also assert reset mid-RUN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/pattern_sched_ctrl.sv
// Colour-bar pattern sequencer: gates the timing generator on panel config, blanks start-up
// frames, then steps the pattern on frame boundaries by dwell timer or host request.
module pattern_sched_ctrl #(
    parameter int NUM_PATTERNS = 8,
    parameter int PAT_W        = 3,
    parameter int FRAME_W      = 9,
    parameter int BLANK_FRAMES = 121,
    parameter int DWELL_FRAMES = 60,
    parameter int RSTN_FRAME   = 6
) (
    input  logic               i_sysclk,
    input  logic               w_sysclk_arstn,
    input  logic               i_confdone,
    input  logic               i_vs,
    input  logic               i_req_valid,
    input  logic [PAT_W-1:0]   i_req_pattern,
    input  logic               i_req_hold,
    output logic               o_req_ready,
    output logic               o_req_err,
    output logic               o_gen_rstn,
    output logic               o_pixel_rstn,
    output logic               o_blank,
    output logic [PAT_W-1:0]   o_pattern_sel,
    output logic [FRAME_W-1:0] o_frame_cnt,
    output logic [1:0]         o_state
);

    localparam int BLK_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam int DWL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [BLK_W-1:0]   BLK_LAST  = BLK_W'(BLANK_FRAMES - 1);
    localparam logic [DWL_W-1:0]   DWL_LAST  = DWL_W'(DWELL_FRAMES - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST  = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [PAT_W:0]     PAT_LIMIT = (PAT_W + 1)'(NUM_PATTERNS);
    localparam logic [FRAME_W-1:0] RSTN_AT   = FRAME_W'(RSTN_FRAME);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_CONF = 2'd1,
        ST_BLANK     = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               conf_meta_q, conf_s_q, vs_d_q;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [BLK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [DWL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic               pend_q, pend_d, pend_hold_q, pend_hold_d, hold_q, hold_d;
    logic [PAT_W-1:0]   pend_pat_q, pend_pat_d, pat_q, pat_d;
    logic               gen_rstn_q, gen_rstn_d, pixel_rstn_q, pixel_rstn_d;
    logic               blank_q, blank_d, req_ready_q, req_ready_d, req_err_q, req_err_d;
    logic               tick_s, accept_s, req_bad_s;

    // Synchronise i_confdone and delay vsync for falling-edge detection.
    always_ff @(posedge i_sysclk or negedge w_sysclk_arstn) begin
        if (!w_sysclk_arstn) begin
            conf_meta_q <= 1'b0;
            conf_s_q    <= 1'b0;
            vs_d_q      <= 1'b0;
        end else begin
            conf_meta_q <= i_confdone;
            conf_s_q    <= conf_meta_q;
            vs_d_q      <= i_vs;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        tick_s       = vs_d_q & ~i_vs;
        accept_s     = i_req_valid & req_ready_q;
        req_bad_s    = ({1'b0, i_req_pattern} >= PAT_LIMIT);
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        pend_d       = pend_q;
        pend_pat_d   = pend_pat_q;
        pend_hold_d  = pend_hold_q;
        hold_d       = hold_q;
        pat_d        = pat_q;
        gen_rstn_d   = gen_rstn_q;
        pixel_rstn_d = pixel_rstn_q;
        blank_d      = blank_q;
        req_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_CONF;
            end
            ST_WAIT_CONF: begin
                gen_rstn_d   = 1'b0;
                pixel_rstn_d = 1'b0;
                blank_d      = 1'b1;
                pat_d        = {PAT_W{1'b0}};
                frame_cnt_d  = {FRAME_W{1'b0}};
                blank_cnt_d  = {BLK_W{1'b0}};
                dwell_cnt_d  = {DWL_W{1'b0}};
                hold_d       = 1'b0;
                pend_d       = 1'b0;
                if (conf_s_q) begin
                    state_d    = ST_BLANK;
                    gen_rstn_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_CONF;
                end
            end
            ST_BLANK, ST_RUN: begin
                if (!conf_s_q) begin
                    state_d      = ST_WAIT_CONF;
                    gen_rstn_d   = 1'b0;
                    pixel_rstn_d = 1'b0;
                    blank_d      = 1'b1;
                    pat_d        = {PAT_W{1'b0}};
                    frame_cnt_d  = {FRAME_W{1'b0}};
                    hold_d       = 1'b0;
                    pend_d       = 1'b0;
                end else begin
                    frame_cnt_d  = frame_cnt_q + FRAME_W'(tick_s);
                    // Release is sticky; a later counter wrap past RSTN_AT changes nothing.
                    pixel_rstn_d = pixel_rstn_q | (frame_cnt_d == RSTN_AT);
                    if (state_q == ST_BLANK) begin
                        blank_d = 1'b1;
                        if (tick_s) begin
                            blank_cnt_d = blank_cnt_q + BLK_W'(1'b1);
                            if (blank_cnt_q == BLK_LAST) begin
                                state_d     = ST_RUN;
                                blank_d     = 1'b0;
                                pat_d       = {PAT_W{1'b0}};
                                dwell_cnt_d = {DWL_W{1'b0}};
                            end else begin
                                state_d = ST_BLANK;
                            end
                        end else begin
                            blank_cnt_d = blank_cnt_q;
                        end
                    end else begin
                        blank_d   = 1'b0;
                        req_err_d = accept_s & req_bad_s;
                        if (accept_s && !req_bad_s) begin
                            pend_d      = 1'b1;
                            pend_pat_d  = i_req_pattern;
                            pend_hold_d = i_req_hold;
                        end else begin
                            pend_d = pend_q;
                        end
                        // A request accepted on the tick cycle is applied immediately.
                        if (tick_s) begin
                            if (pend_d) begin
                                pat_d       = pend_pat_d;
                                hold_d      = pend_hold_d;
                                dwell_cnt_d = {DWL_W{1'b0}};
                                pend_d      = 1'b0;
                            end else if (hold_q) begin
                                dwell_cnt_d = dwell_cnt_q;
                            end else if (dwell_cnt_q == DWL_LAST) begin
                                pat_d       = (pat_q == PAT_LAST) ? {PAT_W{1'b0}} : pat_q + PAT_W'(1'b1);
                                dwell_cnt_d = {DWL_W{1'b0}};
                            end else begin
                                dwell_cnt_d = dwell_cnt_q + DWL_W'(1'b1);
                            end
                        end else begin
                            dwell_cnt_d = dwell_cnt_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_RUN) & ~pend_d;
    end

    // State and output registers.
    always_ff @(posedge i_sysclk or negedge w_sysclk_arstn) begin
        if (!w_sysclk_arstn) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= {FRAME_W{1'b0}};
            blank_cnt_q  <= {BLK_W{1'b0}};
            dwell_cnt_q  <= {DWL_W{1'b0}};
            pend_q       <= 1'b0;
            pend_pat_q   <= {PAT_W{1'b0}};
            pend_hold_q  <= 1'b0;
            hold_q       <= 1'b0;
            pat_q        <= {PAT_W{1'b0}};
            gen_rstn_q   <= 1'b0;
            pixel_rstn_q <= 1'b0;
            blank_q      <= 1'b1;
            req_ready_q  <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            pend_q       <= pend_d;
            pend_pat_q   <= pend_pat_d;
            pend_hold_q  <= pend_hold_d;
            hold_q       <= hold_d;
            pat_q        <= pat_d;
            gen_rstn_q   <= gen_rstn_d;
            pixel_rstn_q <= pixel_rstn_d;
            blank_q      <= blank_d;
            req_ready_q  <= req_ready_d;
            req_err_q    <= req_err_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_req_err     = req_err_q;
    assign o_gen_rstn    = gen_rstn_q;
    assign o_pixel_rstn  = pixel_rstn_q;
    assign o_blank       = blank_q;
    assign o_pattern_sel = pat_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_pattern_sched_ctrl.sv
// Scoreboard bench for pattern_sched_ctrl: a frame-level model pushes expected outputs per
// frame tick; they are popped and compared once the DUT has registered that tick.
module tb_pattern_sched_ctrl;

    localparam int NP  = 8;
    localparam int PW  = 4;
    localparam int FW  = 9;
    localparam int BLK = 121;
    localparam int DW  = 2;
    localparam int RF  = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          confdone = 1'b0;
    logic          vs = 1'b0;
    logic          req_valid = 1'b0;
    logic [PW-1:0] req_pattern = 4'd0;
    logic          req_hold = 1'b0;
    logic          req_ready, req_err, gen_rstn, pixel_rstn, blank;
    logic [PW-1:0] pattern_sel;
    logic [FW-1:0] frame_cnt;
    logic [1:0]    state;

    pattern_sched_ctrl #(
        .NUM_PATTERNS(NP), .PAT_W(PW), .FRAME_W(FW),
        .BLANK_FRAMES(BLK), .DWELL_FRAMES(DW), .RSTN_FRAME(RF)
    ) dut (
        .i_sysclk(clk), .w_sysclk_arstn(rst_n), .i_confdone(confdone), .i_vs(vs),
        .i_req_valid(req_valid), .i_req_pattern(req_pattern), .i_req_hold(req_hold),
        .o_req_ready(req_ready), .o_req_err(req_err), .o_gen_rstn(gen_rstn),
        .o_pixel_rstn(pixel_rstn), .o_blank(blank), .o_pattern_sel(pattern_sel),
        .o_frame_cnt(frame_cnt), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] frame;
        logic          blk;
        logic          pix;
        logic [1:0]    st;
        logic [PW-1:0] pat;
        logic          rdy;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad = 0;

    // frame-level reference model
    int            m_st, m_bcnt, m_pat, m_dwell, m_pend_pat;
    bit            m_pix, m_hold, m_pend, m_pend_hold;
    logic [FW-1:0] m_frame;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_st = 1; m_bcnt = 0; m_pat = 0; m_dwell = 0; m_pend_pat = 0;
        m_pix = 1'b0; m_hold = 1'b0; m_pend = 1'b0; m_pend_hold = 1'b0;
        m_frame = 9'd0;
    endtask

    task automatic model_tick();
        exp_t e;
        if (m_st == 2) begin
            m_frame = m_frame + 9'd1;
            m_bcnt++;
            if (m_bcnt == BLK) begin
                m_st = 3; m_pat = 0; m_dwell = 0;
            end
        end else if (m_st == 3) begin
            m_frame = m_frame + 9'd1;
            if (m_pend) begin
                m_pat = m_pend_pat; m_dwell = 0; m_hold = m_pend_hold; m_pend = 1'b0;
            end else if (m_hold) begin
                m_dwell = m_dwell;
            end else if (m_dwell == DW - 1) begin
                m_pat = (m_pat == NP - 1) ? 0 : m_pat + 1;
                m_dwell = 0;
            end else begin
                m_dwell++;
            end
        end
        if (m_st >= 2 && m_frame == 9'(RF)) m_pix = 1'b1;
        e.frame = m_frame;
        e.blk   = (m_st != 3);
        e.pix   = m_pix;
        e.st    = 2'(m_st);
        e.pat   = 4'(m_pat);
        e.rdy   = (m_st == 3) && !m_pend;
        sb_q.push_back(e);
    endtask

    // One frame: vsync pulse, optional request on the tick cycle, then compare.
    task automatic run_frame(input bit rq, input int rp, input bit rh);
        exp_t e;
        if (rq) begin
            m_pend = 1'b1; m_pend_pat = rp; m_pend_hold = rh;
        end
        model_tick();
        vs = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        if (rq) begin
            req_valid = 1'b1; req_pattern = 4'(rp); req_hold = rh;
        end
        @(negedge clk);
        req_valid = 1'b0;
        e = sb_q.pop_front();
        check_eq("frame_cnt", frame_cnt, e.frame);
        check_eq("blank", blank, e.blk);
        check_eq("pixel_rstn", pixel_rstn, e.pix);
        check_eq("state", state, e.st);
        check_eq("pattern_sel", pattern_sel, e.pat);
        check_eq("req_ready", req_ready, e.rdy);
        repeat (4) @(negedge clk);
    endtask

    // Mid-frame host request held for one cycle.
    task automatic host_req(input int rp, input bit rh);
        bit oor;
        oor = (rp >= NP);
        check_eq("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_pattern = 4'(rp); req_hold = rh;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("ready_after_accept", req_ready, oor);
        check_eq("err_pulse", req_err, oor);
        @(negedge clk);
        check_eq("err_cleared", req_err, 1'b0);
        check_eq("pattern_before_tick", pattern_sel, m_pat);
        if (!oor) begin
            m_pend = 1'b1; m_pend_pat = rp; m_pend_hold = rh;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_gen_rstn"}, gen_rstn, 1'b0);
        check_eq({tag, "_pixel_rstn"}, pixel_rstn, 1'b0);
        check_eq({tag, "_blank"}, blank, 1'b1);
        check_eq({tag, "_pattern"}, pattern_sel, 4'd0);
        check_eq({tag, "_frame"}, frame_cnt, 9'd0);
        check_eq({tag, "_ready"}, req_ready, 1'b0);
        check_eq({tag, "_err"}, req_err, 1'b0);
        check_eq({tag, "_state"}, state, 2'd0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("wait_conf_state", state, 2'd1);
        repeat (2) run_frame(1'b0, 0, 1'b0);

        // config done: generator enabled two sync stages plus one cycle later
        confdone = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("gen_rstn_pre", gen_rstn, 1'b0);
        @(negedge clk);
        check_eq("gen_rstn_on", gen_rstn, 1'b1);
        check_eq("blank_state", state, 2'd2);
        m_st = 2;
        repeat (BLK) run_frame(1'b0, 0, 1'b0);

        // auto-advance through all patterns and wrap
        repeat (16) run_frame(1'b0, 0, 1'b0);

        host_req(5, 1'b1);
        repeat (11) run_frame(1'b0, 0, 1'b0);
        host_req(2, 1'b0);
        repeat (3) run_frame(1'b0, 0, 1'b0);

        // request landing on a tick where auto-advance would also fire
        while (m_dwell != DW - 1) run_frame(1'b0, 0, 1'b0);
        run_frame(1'b1, 6, 1'b0);

        host_req(9, 1'b0);
        repeat (2) run_frame(1'b0, 0, 1'b0);

        // loss of panel config during RUN
        confdone = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("drop_state", state, 2'd1);
        check_eq("drop_gen_rstn", gen_rstn, 1'b0);
        check_eq("drop_pixel_rstn", pixel_rstn, 1'b0);
        check_eq("drop_blank", blank, 1'b1);
        check_eq("drop_pattern", pattern_sel, 4'd0);
        check_eq("drop_frame", frame_cnt, 9'd0);
        check_eq("drop_ready", req_ready, 1'b0);
        model_clear();

        confdone = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reconf_gen_rstn", gen_rstn, 1'b1);
        check_eq("reconf_state", state, 2'd2);
        m_st = 2;
        repeat (BLK) run_frame(1'b0, 0, 1'b0);
        repeat (3) run_frame(1'b0, 0, 1'b0);

        // asynchronous reset mid-RUN, away from any clock edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
